secuenciador_alsu: RTL and testbench
====================================

Name: secuenciador_alsu

Overview:
Control-side counterpart of the 16-bit ALU. It accepts instruction words over a valid/ready handshake and fetches both operands from the register bank. It drives the ALU operands and selector, captures the ALU result and flags, computes the overflow the ALU does not produce, maintains the status register, and writes results back to the register bank. It executes one instruction at a time.

Parameters:
ANCHO, 16, datapath width; must match ALU width.
ANCHO_DIR, 4, register-bank address width; instruction width = 4 + 3*ANCHO_DIR.

Ports:
Reloj  input  1  single clock; all state on rising edge.
Reset_n  input  1  asynchronous, active-low reset.
InstrValida  input  1  instruction word valid.
Instruccion  input  16  [15:12] opcode (= ALU selector), [11:8] Rd, [7:4] Ra, [3:0] Rb.
InstrLista  output  1  ready; high only in IDLE.
DirLecturaA  output  4  bank read address A (= latched Ra).
DirLecturaB  output  4  bank read address B (= latched Rb).
DatoLecturaA  input  16  bank read data A; registered, valid the cycle after the address.
DatoLecturaB  input  16  bank read data B; same timing as A.
AluEntradaA  output  16  ALU operand A (registered).
AluEntradaB  output  16  ALU operand B (registered).
AluSelector  output  4  ALU operation select (latched opcode).
AluSalida  input  16  ALU result (combinational).
AluAcarreo  input  1  ALU carry/borrow; may be Z for non-arithmetic ops.
AluDesbordamiento  input  1  ALU overflow; ignored, always undriven.
EscrituraHab  output  1  bank write enable; write occurs at the rising edge ending the ESCRIBIR cycle.
DirEscritura  output  4  write address (latched Rd).
DatoEscritura  output  16  write data (captured ALU result).
Status  output  4  {N,Z,C,V}.
Hecho  output  1  one-cycle pulse in ESCRIBIR.
Ilegal  output  1  one-cycle pulse with Hecho for reserved opcodes.

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE. Latched instruction, operand registers, result, Status, EscrituraHab, Hecho and Ilegal all read 0. InstrLista reads 1 once state is IDLE. An instruction in flight is abandoned with no write.
- FSM: IDLE -> LEER -> CARGAR -> OPERAR -> ESCRIBIR -> IDLE.
  - IDLE: InstrLista=1. On edge T with InstrValida=1, latch Instruccion and go to LEER. InstrValida while not IDLE is ignored and never latched.
  - LEER: DirLecturaA/B held.
  - CARGAR: at edge T+2, DatoLecturaA/B -> AluEntradaA/B.
  - OPERAR: ALU inputs stable. At edge T+3, sample AluSalida, AluAcarreo and the operand sign bits.
  - ESCRIBIR (cycle after edge T+3): Hecho=1. EscrituraHab=1 unless opcode is 1010 (TEST) or illegal. Status is updated at edge T+4.
- Throughput: next acceptance no earlier than edge T+5.
- Reserved opcodes 1001 and 1011:
  - Ilegal=1 with Hecho in ESCRIBIR.
  - No write, Status unchanged.
  - Same 4-cycle latency as legal ops.
- Status update rules (R = result, A = operand A, B' = operand B, or 1 for INC/DEC):
  - N=R[15], Z=(R==0) on every legal op.
  - C=AluAcarreo on DEC, ADD, SUB, INC, TEST and shifts/rotates 1100-1111. C holds on NOT, AND, XOR, OR, MOV; the Z carry is never sampled. For subtraction, C=1 means borrow.
  - V, add (ADD/INC) = (A[15]==B'[15]) && (R[15]!=A[15]).
  - V, subtract (SUB/DEC/TEST) = (A[15]!=B'[15]) && (R[15]!=A[15]).
  - V holds on all other ops.
- Register aliasing: any combination of equal Rd, Ra, Rb is legal; no hazard exists because execution is sequential. Register 0 is writable.
- AluSelector holds the last latched opcode between instructions.

Test Plan:
- ADD (0101), R1=16'h7FFF, R2=16'h0001, Rd=3, accepted at T -> EscrituraHab, Hecho in the cycle after edge T+3; DatoEscritura=16'h8000, DirEscritura=3; Status=4'b1001 after T+4.
- SUB (0110), A=16'h0000, B=16'h0001 -> DatoEscritura=16'hFFFF; Status N=1, Z=0, C=1, V=0.
- TEST (1010), A=B=16'h1234 -> EscrituraHab stays 0, Hecho=1; Status=4'b0100.
- Status preset to C=1, V=1, then AND with A=16'h00F0, B=16'h0F00 -> result 0, written; Status=4'b0111 (C, V held).
- SR (1110), A=16'h0001, prior V=0 -> DatoEscritura=16'h0000; C=1, Z=1, V=0; InstrValida held high during the op -> only one acceptance.
- Opcode 1001 -> Ilegal=Hecho=1 at T+3 cycle, no write, Status unchanged. Then a new ADD with Reset_n pulsed low during OPERAR -> all outputs 0 immediately, no write, InstrLista=1 after release.

Source files
------------

// File: rtl/secuenciador_alsu.sv
// Sequencer for the 16-bit ALU: fetches operands from the register bank, runs one
// instruction at a time, derives the overflow flag and writes the result back.
module secuenciador_alsu #(
  parameter int ANCHO     = 16,
  parameter int ANCHO_DIR = 4
) (
  input  logic                       Reloj,
  input  logic                       Reset_n,
  input  logic                       InstrValida,
  input  logic [4+3*ANCHO_DIR-1:0]   Instruccion,
  output logic                       InstrLista,
  output logic [ANCHO_DIR-1:0]       DirLecturaA,
  output logic [ANCHO_DIR-1:0]       DirLecturaB,
  input  logic [ANCHO-1:0]           DatoLecturaA,
  input  logic [ANCHO-1:0]           DatoLecturaB,
  output logic [ANCHO-1:0]           AluEntradaA,
  output logic [ANCHO-1:0]           AluEntradaB,
  output logic [3:0]                 AluSelector,
  input  logic [ANCHO-1:0]           AluSalida,
  input  logic                       AluAcarreo,
  input  logic                       AluDesbordamiento,
  output logic                       EscrituraHab,
  output logic [ANCHO_DIR-1:0]       DirEscritura,
  output logic [ANCHO-1:0]           DatoEscritura,
  output logic [3:0]                 Status,
  output logic                       Hecho,
  output logic                       Ilegal
);

  localparam int ANCHO_INSTR = 4 + 3*ANCHO_DIR;

  typedef enum logic [2:0] {IDLE, LEER, CARGAR, OPERAR, ESCRIBIR} estado_t;

  estado_t                 state_reg, state_next;
  logic [ANCHO_INSTR-1:0]  instr_reg;
  logic [ANCHO-1:0]        op_a_reg, op_b_reg, result_reg;
  logic                    carry_reg, sign_a_reg, sign_b_reg;
  logic [3:0]              status_reg, status_next;

  logic [3:0] opcode;
  logic       is_illegal, is_test, uses_carry, is_add, is_sub, b_is_one;
  logic       unused_desbordamiento;

  // The ALU never drives a meaningful overflow; it is recomputed here instead.
  assign unused_desbordamiento = AluDesbordamiento;

  assign opcode       = instr_reg[ANCHO_INSTR-1 -: 4];
  assign DirEscritura = instr_reg[3*ANCHO_DIR-1 -: ANCHO_DIR];
  assign DirLecturaA  = instr_reg[2*ANCHO_DIR-1 -: ANCHO_DIR];
  assign DirLecturaB  = instr_reg[ANCHO_DIR-1:0];
  assign AluSelector  = opcode;
  assign AluEntradaA  = op_a_reg;
  assign AluEntradaB  = op_b_reg;
  assign DatoEscritura = result_reg;
  assign Status       = status_reg;

  always_comb begin
    is_illegal = (opcode == 4'b1001) || (opcode == 4'b1011);
    is_test    = (opcode == 4'b1010);
    is_add     = (opcode == 4'b0101) || (opcode == 4'b0111);
    is_sub     = (opcode == 4'b0100) || (opcode == 4'b0110) || is_test;
    b_is_one   = (opcode == 4'b0100) || (opcode == 4'b0111);
    uses_carry = is_add || is_sub || (opcode[3:2] == 2'b11);
  end

  // V uses the sign of the effective second operand (+1 for INC/DEC).
  always_comb begin
    status_next[3] = result_reg[ANCHO-1];
    status_next[2] = (result_reg == '0);
    status_next[1] = uses_carry ? carry_reg : status_reg[1];
    if (is_add)
      status_next[0] = (sign_a_reg == sign_b_reg) && (result_reg[ANCHO-1] != sign_a_reg);
    else if (is_sub)
      status_next[0] = (sign_a_reg != sign_b_reg) && (result_reg[ANCHO-1] != sign_a_reg);
    else
      status_next[0] = status_reg[0];
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      instr_reg  <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      status_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && InstrValida)
        instr_reg <= Instruccion;
      if (state_reg == CARGAR) begin
        op_a_reg <= DatoLecturaA;
        op_b_reg <= DatoLecturaB;
      end
      if (state_reg == OPERAR) begin
        result_reg <= AluSalida;
        // Carry may float on logic ops, so it is only sampled where it means something.
        carry_reg  <= uses_carry ? AluAcarreo : 1'b0;
        sign_a_reg <= op_a_reg[ANCHO-1];
        sign_b_reg <= b_is_one ? 1'b0 : op_b_reg[ANCHO-1];
      end
      if (state_reg == ESCRIBIR && !is_illegal)
        status_reg <= status_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    InstrLista   = 1'b0;
    Hecho        = 1'b0;
    Ilegal       = 1'b0;
    EscrituraHab = 1'b0;
    case (state_reg)
      IDLE: begin
        InstrLista = 1'b1;
        if (InstrValida) state_next = LEER;
      end
      LEER:   state_next = CARGAR;
      CARGAR: state_next = OPERAR;
      OPERAR: state_next = ESCRIBIR;
      ESCRIBIR: begin
        Hecho        = 1'b1;
        Ilegal       = is_illegal;
        EscrituraHab = !is_illegal && !is_test;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_secuenciador_alsu.sv
// Scoreboard bench for secuenciador_alsu: models the register bank and ALU, issues
// directed instructions and checks each completion against hand-computed results.
module tb_secuenciador_alsu;

  logic        Reloj = 1'b0;
  logic        Reset_n = 1'b0;
  logic        InstrValida = 1'b0;
  logic [15:0] Instruccion = 16'h0000;
  logic        InstrLista;
  logic [3:0]  DirLecturaA, DirLecturaB;
  logic [15:0] DatoLecturaA, DatoLecturaB;
  logic [15:0] AluEntradaA, AluEntradaB;
  logic [3:0]  AluSelector;
  logic [15:0] AluSalida;
  logic        AluAcarreo;
  logic        AluDesbordamiento;
  logic        EscrituraHab;
  logic [3:0]  DirEscritura;
  logic [15:0] DatoEscritura;
  logic [3:0]  Status;
  logic        Hecho, Ilegal;

  secuenciador_alsu #(.ANCHO(16), .ANCHO_DIR(4)) dut (
    .Reloj(Reloj), .Reset_n(Reset_n), .InstrValida(InstrValida), .Instruccion(Instruccion),
    .InstrLista(InstrLista), .DirLecturaA(DirLecturaA), .DirLecturaB(DirLecturaB),
    .DatoLecturaA(DatoLecturaA), .DatoLecturaB(DatoLecturaB),
    .AluEntradaA(AluEntradaA), .AluEntradaB(AluEntradaB), .AluSelector(AluSelector),
    .AluSalida(AluSalida), .AluAcarreo(AluAcarreo), .AluDesbordamiento(AluDesbordamiento),
    .EscrituraHab(EscrituraHab), .DirEscritura(DirEscritura), .DatoEscritura(DatoEscritura),
    .Status(Status), .Hecho(Hecho), .Ilegal(Ilegal)
  );

  always #5 Reloj = ~Reloj;

  int cyc = 0;
  always @(posedge Reloj) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register bank: registered read, write at the edge ending the write cycle.
  logic [15:0] bank [16];
  logic        preload = 1'b1;
  always @(posedge Reloj) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        case (i)
          0:  bank[i] <= 16'h5555;
          1:  bank[i] <= 16'h7FFF;
          2:  bank[i] <= 16'h0001;
          6:  bank[i] <= 16'h1234;
          7:  bank[i] <= 16'hFFFF;
          9:  bank[i] <= 16'h00F0;
          10: bank[i] <= 16'h0F00;
          11: bank[i] <= 16'hBEEF;
          12: bank[i] <= 16'hC0DE;
          14: bank[i] <= 16'hABCD;
          default: bank[i] <= 16'h0000;
        endcase
      end
    end else if (EscrituraHab) begin
      bank[DirEscritura] <= DatoEscritura;
    end
    DatoLecturaA <= bank[DirLecturaA];
    DatoLecturaB <= bank[DirLecturaB];
  end

  // External ALU; logic ops drive a junk carry of 0 that must not be sampled.
  assign AluDesbordamiento = 1'b0;
  always_comb begin
    AluSalida  = 16'h0000;
    AluAcarreo = 1'b0;
    case (AluSelector)
      4'b0000: AluSalida = ~AluEntradaA;
      4'b0001: AluSalida = AluEntradaA & AluEntradaB;
      4'b0010: AluSalida = AluEntradaA ^ AluEntradaB;
      4'b0011: AluSalida = AluEntradaA | AluEntradaB;
      4'b0100: begin AluSalida = AluEntradaA - 16'd1; AluAcarreo = (AluEntradaA == 16'd0); end
      4'b0101: {AluAcarreo, AluSalida} = {1'b0, AluEntradaA} + {1'b0, AluEntradaB};
      4'b0110, 4'b1010: begin
        AluSalida  = AluEntradaA - AluEntradaB;
        AluAcarreo = (AluEntradaA < AluEntradaB);
      end
      4'b0111: {AluAcarreo, AluSalida} = {1'b0, AluEntradaA} + 17'd1;
      4'b1000: AluSalida = AluEntradaA;
      4'b1100: begin AluSalida = {AluEntradaA[14:0], 1'b0}; AluAcarreo = AluEntradaA[15]; end
      4'b1101: begin AluSalida = {AluEntradaA[14:0], AluEntradaA[15]}; AluAcarreo = AluEntradaA[15]; end
      4'b1110: begin AluSalida = {1'b0, AluEntradaA[15:1]}; AluAcarreo = AluEntradaA[0]; end
      4'b1111: begin AluSalida = {AluEntradaA[0], AluEntradaA[15:1]}; AluAcarreo = AluEntradaA[0]; end
      default: AluSalida = 16'h0000;
    endcase
  end

  typedef struct {
    int          t;
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
    logic        il;
    logic [3:0]  st;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic       pend = 1'b0;
  logic [3:0] pend_st = 4'h0;

  // Monitor: pops an expectation on every Hecho, then checks Status one cycle later.
  always @(negedge Reloj) begin
    if (!Reset_n) begin
      pend <= 1'b0;
    end else begin
      if (pend) chk("status", 32'(Status), 32'(pend_st));
      pend <= 1'b0;
      if (Hecho) begin
        if (sb.size() == 0) begin
          chk("spurious_hecho", 32'(Hecho), 32'(0));
        end else begin
          e = sb.pop_front();
          $display("txn t=%0d sel=%h we=%b dir=%0d dato=%h ilegal=%b", e.t, AluSelector,
                   EscrituraHab, DirEscritura, DatoEscritura, Ilegal);
          chk("latency", 32'(cyc - e.t), 32'(3));
          chk("escritura_hab", 32'(EscrituraHab), 32'(e.we));
          chk("ilegal", 32'(Ilegal), 32'(e.il));
          chk("dir_escritura", 32'(DirEscritura), 32'(e.rd));
          if (e.we) chk("dato_escritura", 32'(DatoEscritura), 32'(e.data));
          pend    <= 1'b1;
          pend_st <= e.st;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!InstrLista && n < 30) begin
      @(negedge Reloj);
      n++;
    end
    chk("ready_wait", 32'(InstrLista), 32'(1));
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic we, input logic [15:0] data,
                       input logic il, input logic [3:0] st, input bit push, input bit hold);
    exp_t x;
    @(negedge Reloj);
    wait_ready();
    Instruccion = {op, rd, ra, rb};
    InstrValida = 1'b1;
    @(posedge Reloj);
    #1;
    x.t = cyc; x.we = we; x.rd = rd; x.data = data; x.il = il; x.st = st;
    if (push) sb.push_back(x);
    if (hold) Instruccion = {4'b0101, 4'hC, 4'h1, 4'h2};
    else InstrValida = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge Reloj);
    chk("rst_lista", 32'(InstrLista), 32'(1));
    chk("rst_hecho", 32'(Hecho), 32'(0));
    chk("rst_hab", 32'(EscrituraHab), 32'(0));
    chk("rst_ilegal", 32'(Ilegal), 32'(0));
    chk("rst_status", 32'(Status), 32'(0));
    chk("rst_op_a", 32'(AluEntradaA), 32'(0));
    chk("rst_op_b", 32'(AluEntradaB), 32'(0));
    chk("rst_dato", 32'(DatoEscritura), 32'(0));
    chk("rst_sel", 32'(AluSelector), 32'(0));
    Reset_n = 1'b1;
    preload = 1'b0;

    issue(4'b0101, 4'd3, 4'd1, 4'd2, 1'b1, 16'h8000, 1'b0, 4'b1001, 1, 0); // ADD overflow
    issue(4'b0110, 4'd5, 4'd4, 4'd2, 1'b1, 16'hFFFF, 1'b0, 4'b1010, 1, 0); // SUB borrow
    issue(4'b1010, 4'd6, 4'd6, 4'd6, 1'b0, 16'h0000, 1'b0, 4'b0100, 1, 0); // TEST, no write

    // SR with InstrValida held high: a single acceptance, busy until the write cycle ends.
    issue(4'b1110, 4'd7, 4'd2, 4'd0, 1'b1, 16'h0000, 1'b0, 4'b0110, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge Reloj);
      chk("busy_lista", 32'(InstrLista), 32'(0));
    end
    @(negedge Reloj);
    chk("idle_lista", 32'(InstrLista), 32'(1));
    InstrValida = 1'b0;

    issue(4'b0101, 4'd8, 4'd3, 4'd3, 1'b1, 16'h0000, 1'b0, 4'b0111, 1, 0); // preset C,V
    issue(4'b0001, 4'd0, 4'd9, 4'd10, 1'b1, 16'h0000, 1'b0, 4'b0111, 1, 0); // AND, C/V hold
    issue(4'b1001, 4'd11, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b1, 4'b0111, 1, 0); // reserved

    // ADD abandoned by a reset in OPERAR.
    issue(4'b0101, 4'd14, 4'd1, 4'd2, 1'b1, 16'h8000, 1'b0, 4'b1001, 0, 0);
    repeat (3) @(negedge Reloj);
    Reset_n = 1'b0;
    #1;
    chk("arst_hab", 32'(EscrituraHab), 32'(0));
    chk("arst_hecho", 32'(Hecho), 32'(0));
    chk("arst_status", 32'(Status), 32'(0));
    chk("arst_op_a", 32'(AluEntradaA), 32'(0));
    chk("arst_dato", 32'(DatoEscritura), 32'(0));
    chk("arst_sel", 32'(AluSelector), 32'(0));
    @(negedge Reloj);
    Reset_n = 1'b1;
    @(negedge Reloj);
    chk("arst_lista", 32'(InstrLista), 32'(1));
    repeat (6) @(negedge Reloj);
    chk("arst_no_write", 32'(bank[14]), 32'(16'hABCD));

    issue(4'b0101, 4'd13, 4'd1, 4'd2, 1'b1, 16'h8000, 1'b0, 4'b1001, 1, 0); // ADD after reset
    issue(4'b0100, 4'd15, 4'd4, 4'd0, 1'b1, 16'hFFFF, 1'b0, 4'b1010, 1, 0); // DEC of 0
    issue(4'b1011, 4'd12, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b1, 4'b1010, 1, 0); // reserved

    n = 0;
    while ((sb.size() != 0 || pend) && n < 40) begin
      @(negedge Reloj);
      n++;
    end
    @(negedge Reloj);
    chk("drain", 32'(sb.size()), 32'(0));
    chk("bank_r0", 32'(bank[0]), 32'(16'h0000));
    chk("bank_r3", 32'(bank[3]), 32'(16'h8000));
    chk("bank_r5", 32'(bank[5]), 32'(16'hFFFF));
    chk("bank_r7", 32'(bank[7]), 32'(16'h0000));
    chk("bank_r11", 32'(bank[11]), 32'(16'hBEEF));
    chk("bank_r12", 32'(bank[12]), 32'(16'hC0DE));
    chk("bank_r13", 32'(bank[13]), 32'(16'h8000));
    chk("bank_r15", 32'(bank[15]), 32'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
